gt_arbiter: RTL
===============

// Module: gt_arbiter
// PURPOSE
//  Shares one clocked gt comparator between N_REQ requesters. Each cycle one
//    valid requester is granted round-robin; its operand pair drives the gt.
//  The comparator output is returned GT_LATENCY cycles later to the issuing
//    requester only.
//  Sits between the gt unit (instantiated outside this block) and datapath
//    clients that need a greater-than result.
// PARAMETERS
//  N_REQ       4   number of requesters (2..16)
//  WIDTH       32  operand width; gt_a/gt_b width
//  GT_LATENCY  1   cycles from operands at gt input (sampled at posedge) to gt_z valid; >=1
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   N_REQ        requester i has an operand pair pending
//  req_a      in   N_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N_REQ*WIDTH  operand b, same packing
//  req_ready  out  N_REQ        one-hot grant; transfer when valid&ready
//  gt_a       out  WIDTH        operand a to shared gt
//  gt_b       out  WIDTH        operand b to shared gt
//  gt_z       in   1            result from shared gt
//  rsp_valid  out  N_REQ        one-cycle pulse, result for requester i
//  rsp_z      out  1            result bit, meaningful when any rsp_valid set
// BEHAVIOUR
//  Arbitration (combinational):
//    - Winner = first valid index at or after ptr, wrapping.
//    - req_ready = onehot(winner), or 0 if no valid.
//    - Requesters hold valid/operands stable until ready (no retraction).
//  Issue:
//    - gt_a/gt_b = winner's operands in the grant cycle.
//    - All zeros when no grant; never X.
//  Pointer:
//    - On grant, ptr <= winner+1 mod N_REQ; otherwise unchanged.
//    - Reset ptr = 0.
//  Tag pipe:
//    - GT_LATENCY-deep shift register of {vld, id[$clog2(N_REQ)-1:0]}.
//    - Stage0 loads {grant, winner} every cycle.
//  Response (registered outputs):
//    - rsp_valid <= onehot(id) & vld at the pipe tail.
//    - rsp_z <= gt_z when tail vld, else 0.
//    - Net: grant at cycle t -> rsp_valid/rsp_z visible after posedge t+GT_LATENCY+1.
//  Flow: no response backpressure; throughput 1 request per cycle.
//    - Results return in issue order.
//  Fairness: a continuously valid requester waits at most N_REQ-1 cycles.
//  Reset (synchronous, any time):
//    - ptr=0; tag pipe vld all 0; rsp_valid=0; rsp_z=0.
//    - In-flight operations are discarded: no response after reset.
//    - req_ready=0 while rst high.
//  Simultaneous events: a grant and a response to the same requester in one
//    cycle are independent and both occur.
//  Single requester with N_REQ-1 idle: granted every cycle.
// STRUCTURE
//  gt_arb_defs.vh: ID_W = $clog2(N_REQ) function/macro; tag-field packing macros.
//  Sub-module rr_pick (N_REQ): inputs valid, ptr; outputs onehot grant + index.
//  Tag pipe and response registers live in gt_arbiter.
// TESTING (bench instantiates real gt, GT_LATENCY=1 unless noted)
//  1 Req0 only, a=5 b=3 -> ready0 same cycle; rsp_valid=0001, rsp_z=1 two edges later.
//  2 Req2 a=7 b=7, then a=3 b=9 back-to-back -> two grants, consecutive
//    rsp_valid=0100, rsp_z 0 then 0.
//  3 All 4 valid continuously, 8 cycles -> grants 0,1,2,3,0,1,2,3.
//    Each rsp routed to its issuer.
//  4 Grant req1 (a=9 b=1) at cycle t, rst high at t+1 -> no rsp_valid ever.
//    ptr=0 after; next grant goes to lowest valid index.
//  5 GT_LATENCY=3 (delayed gt model), req3 a=100 b=99 -> rsp_valid=1000, rsp_z=1
//    four edges after grant.
//  6 Idle cycles -> gt_a=gt_b=0, req_ready=0, rsp_valid=0.

Source files
------------

// File: rtl/gt_arbiter_pkg.sv
// Shared helpers for the gt_arbiter slice: index-width sizing.
package gt_arbiter_pkg;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gt_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
module gt_arbiter_rr_pick
  import gt_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan N_REQ positions starting at ptr; the first valid one wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = j[ID_W-1:0];
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gt_arbiter.sv
// Shares one clocked greater-than unit between N_REQ requesters.
// One request is issued per cycle round-robin; its {valid, id} tag follows the
// gt unit's latency so the result is routed back to the issuer only.
module gt_arbiter
  import gt_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int GT_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         gt_a,
  output logic [WIDTH-1:0]         gt_b,
  input  logic                     gt_z,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_z
);

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  ptr;
  logic             grant_vld;

  // Tag pipe: valid bits are control (reset), ids are data (not reset).
  logic [GT_LATENCY-1:0] tag_vld_p;
  logic [ID_W-1:0]       tag_id_p [GT_LATENCY];
  logic [N_REQ-1:0]      tail_onehot;

  gt_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // No grant is offered while reset is asserted.
  assign grant_vld = pick_any & ~rst;
  assign req_ready = grant_vld ? pick_grant : '0;

  assign tail_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << tag_id_p[GT_LATENCY-1];

  // Route the winner's operands to the gt unit; drive zeros when idle.
  always_comb begin
    gt_a = '0;
    gt_b = '0;
    if (grant_vld) begin
      gt_a = req_a[int'(pick_idx)*WIDTH +: WIDTH];
      gt_b = req_b[int'(pick_idx)*WIDTH +: WIDTH];
    end
  end

  // Control state: pointer, tag valid pipe and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      tag_vld_p <= '0;
      rsp_valid <= '0;
      rsp_z     <= 1'b0;
    end else begin
      if (grant_vld) begin
        ptr <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      // stage 0: issue tag enters alongside operands sampled by the gt unit
      tag_vld_p[0] <= grant_vld;
      for (int i = 1; i < GT_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
      // tail: gt_z is valid for the tagged request
      rsp_valid <= tag_vld_p[GT_LATENCY-1] ? tail_onehot : '0;
      rsp_z     <= tag_vld_p[GT_LATENCY-1] & gt_z;
    end
  end

  // Requester ids ride with the valid bits; they need no reset.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= pick_idx;
    for (int i = 1; i < GT_LATENCY; i++) begin
      tag_id_p[i] <= tag_id_p[i-1];
    end
  end

endmodule
